// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler
//   Arbitrates the single register-file write port between the writeback
//   stage and a long-latency (mul/div) unit. Long-latency results are parked
//   in a small FIFO and drained whenever writeback leaves the port idle. A
//   starvation counter forces the FIFO head through (stalling writeback) once
//   it has waited STARVE_LIMIT cycles. A per-register pending scoreboard is
//   exported to the hazard unit.
//
// Ports
//   clk, rst_n                        clock (rising edge), async active-low reset
//   wb_we, wb_rd, wb_data             writeback write request
//   mu_valid, mu_ready, mu_rd, mu_data long-latency result handshake
//   mu_issue, mu_issue_rd             long-latency op issue (reserves rd)
//   RegWrite, WriteRegister, WriteData register file write port (combinational)
//   stall_wb                          writeback must hold its request
//   pending                           bit i set: register i awaits a result
//   fifo_count                        number of buffered results
module regfile_write_scheduler #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wb_we,
  input  logic [4:0]                    wb_rd,
  input  logic [DATA_W-1:0]             wb_data,
  input  logic                          mu_valid,
  output logic                          mu_ready,
  input  logic [4:0]                    mu_rd,
  input  logic [DATA_W-1:0]             mu_data,
  input  logic                          mu_issue,
  input  logic [4:0]                    mu_issue_rd,
  output logic                          RegWrite,
  output logic [4:0]                    WriteRegister,
  output logic [DATA_W-1:0]             WriteData,
  output logic                          stall_wb,
  output logic [31:0]                   pending,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SC_W  = $clog2(STARVE_LIMIT + 1);

  logic [4:0]        rdMem   [FIFO_DEPTH];
  logic [DATA_W-1:0] dataMem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rdPtr, wrPtr;
  logic [CNT_W-1:0]  count;
  logic [SC_W-1:0]   starveCnt;
  logic [31:0]       pendingQ, pendingNext;

  logic fifoEmpty, starved, wbReq, headGrant, wbGrant, push, pop;
  logic [4:0]        headRd;
  logic [DATA_W-1:0] headData;

  assign headRd   = rdMem[rdPtr];
  assign headData = dataMem[rdPtr];

  // Ready depends on the pre-pop count only; gated by reset so the unit sees
  // no acceptance while rst_n is low.
  assign mu_ready = rst_n && (count < CNT_W'(FIFO_DEPTH));

  always_comb begin
    fifoEmpty = (count == '0);
    starved   = !fifoEmpty && (starveCnt == SC_W'(STARVE_LIMIT));
    wbReq     = wb_we && (wb_rd != '0);
    headGrant = !fifoEmpty && (starved || !wbReq);
    wbGrant   = wbReq && !headGrant;
    // rd 0 results complete the handshake but are never buffered.
    push      = mu_valid && mu_ready && (mu_rd != '0);
    pop       = headGrant;
  end

  always_comb begin
    RegWrite      = 1'b0;
    WriteRegister = '0;
    WriteData     = '0;
    stall_wb      = 1'b0;
    if (rst_n) begin
      stall_wb = starved && wbReq;
      if (headGrant) begin
        RegWrite      = 1'b1;
        WriteRegister = headRd;
        WriteData     = headData;
      end else if (wbGrant) begin
        RegWrite      = 1'b1;
        WriteRegister = wb_rd;
        WriteData     = wb_data;
      end
    end
  end

  // Clear on head write first, then set, so a same-cycle issue wins.
  always_comb begin
    pendingNext = pendingQ;
    if (pop) pendingNext[headRd] = 1'b0;
    if (mu_issue && (mu_issue_rd != '0)) pendingNext[mu_issue_rd] = 1'b1;
    pendingNext[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr     <= '0;
      wrPtr     <= '0;
      count     <= '0;
      starveCnt <= '0;
      pendingQ  <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      count    <= count + CNT_W'(push) - CNT_W'(pop);
      pendingQ <= pendingNext;
      if (fifoEmpty || pop)
        starveCnt <= '0;
      else if (starveCnt != SC_W'(STARVE_LIMIT))
        starveCnt <= starveCnt + SC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rdMem[wrPtr]   <= mu_rd;
      dataMem[wrPtr] <= mu_data;
    end
  end

  assign pending    = pendingQ;
  assign fifo_count = count;

endmodule

// File: doc/regfile_write_scheduler.md
# regfile_write_scheduler

Schedules the single write port of the 32x32-bit register file between the pipeline writeback stage and a long-latency multiply/divide unit. Long-latency results are buffered in a small FIFO and written whenever writeback leaves the port idle. A starvation counter stalls writeback when buffered results wait too long. A per-register pending scoreboard is exported to the hazard unit.

## Interface
- DATA_W, 32, write data width
- FIFO_DEPTH, 2, long-latency result buffer entries (power of 2, ≥2)
- STARVE_LIMIT, 4, cycles a non-empty FIFO head may wait before writeback is stalled (≥1)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- wb_we  in  1  writeback stage write request
- wb_rd  in  5  writeback destination register
- wb_data  in  DATA_W  writeback data
- mu_valid  in  1  long-latency unit result valid
- mu_ready  out  1  scheduler can accept a long-latency result
- mu_rd  in  5  long-latency result destination
- mu_data  in  DATA_W  long-latency result data
- mu_issue  in  1  long-latency op issued this cycle (reserve destination)
- mu_issue_rd  in  5  destination of the issued op
- RegWrite  out  1  register file write enable
- WriteRegister  out  5  register file write address
- WriteData  out  DATA_W  register file write data
- stall_wb  out  1  writeback must hold its request this cycle
- pending  out  32  bit i = register i awaits a long-latency result
- fifo_count  out  $clog2(FIFO_DEPTH)+1  buffered entries

## Operation
- FIFO holds {rd, data} pairs. mu_ready = (fifo_count < FIFO_DEPTH), based on the pre-pop count only (no full-FIFO pass-through).
- Push happens when mu_valid && mu_ready. Results with mu_rd == 0 are handshaken and discarded, not enqueued.
- Per-cycle grant, combinational:
  - starved = FIFO non-empty && starve_cnt == STARVE_LIMIT.
  - The FIFO head is granted if the FIFO is non-empty and (starved, or !wb_we, or wb_rd == 0).
  - Otherwise writeback is granted if wb_we && wb_rd != 0.
  - Otherwise the port is idle: RegWrite = 0, WriteRegister = 0, WriteData = 0.
- Writes to register 0 are never issued, from either source.
- stall_wb = starved && wb_we && wb_rd != 0. While stall_wb is high, the writeback request is not performed, and upstream holds wb_* stable.
- starve_cnt increments, saturating at STARVE_LIMIT, each cycle the FIFO is non-empty and the head is not granted. It clears on every pop and when the FIFO is empty.
- A FIFO head grant pops the entry.
- Simultaneous push and pop leaves fifo_count unchanged, and the new entry lands behind the remaining ones.
- Scoreboard:
  - mu_issue with mu_issue_rd != 0 sets pending[mu_issue_rd].
  - A FIFO head write clears pending[head rd].
  - If set and clear hit the same register in the same cycle, set wins.
  - pending[0] is always 0.
  - Writeback writes do not touch pending.
  - Issuing to an already-pending register is illegal; the hazard unit prevents it, and no behaviour is defined for it.

## Timing
- Grant and RegWrite/WriteRegister/WriteData are combinational in the same cycle. The register file captures on the next rising clk.
- An accepted long-latency result appears at the FIFO head the next cycle. Minimum accept-to-capture latency is 2 rising edges.
- pending is registered. The bit rises the cycle after mu_issue and falls the cycle after the head write.
- While rst_n is low (asynchronous):
  - fifo_count, starve_cnt and pending = 0.
  - RegWrite = 0, WriteRegister = 0, WriteData = 0.
  - stall_wb = 0, mu_ready = 0.
- Reset asserted mid-operation discards buffered entries. mu_ready returns to 1 in the first cycle rst_n is high.
- Maximum wait for a FIFO head is STARVE_LIMIT + 1 cycles.

## Test plan
- Reset mid-stream with 2 entries buffered -> fifo_count = 0, pending = 0, RegWrite = 0 during reset; mu_ready = 1 the first cycle after release.
- Writeback only: wb_we = 1, wb_rd = 5, wb_data = 0xDEADBEEF, FIFO empty -> RegWrite = 1, WriteRegister = 5, WriteData = 0xDEADBEEF the same cycle; stall_wb = 0.
- Idle fill:
  - mu_issue rd = 9, then mu_valid rd = 9, data = 0x1234 with wb_we = 0 -> pending[9] = 1.
  - The next cycle RegWrite = 1, WriteRegister = 9, WriteData = 0x1234.
  - pending[9] = 0 one cycle later.
- Starvation:
  - One FIFO entry (rd = 3) plus continuous wb_we to rd = 7 -> writeback wins 4 cycles, then stall_wb = 1 and rd 3 is written in cycle 5.
  - Writeback rd = 7 is then written in cycle 6 and starve_cnt = 0.
- Full/backpressure: wb_we held high with rd = 1, 3 back-to-back mu_valid -> mu_ready falls after 2 accepts; the 3rd is accepted only after a pop; order of writes is preserved.
- Register 0 handling:
  - mu_rd = 0 is accepted with no write and fifo_count unchanged.
  - wb_rd = 0 with FIFO non-empty: the FIFO head is written instead, RegWrite never targets 0.
  - mu_issue_rd = 0 leaves pending = 0.
